// File: rtl/neuron_pkg.sv
// neuron_pkg: shared FSM state type, Q8.8 constants and output saturation
package neuron_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    localparam int Q_DATA_W = 16;
    localparam int Q_FRAC_BITS = 8;
    localparam int SAT_IN_W = 64;
    localparam logic signed [SAT_IN_W-1:0] SAT_MAX = 64'sh7FFF;
    localparam logic signed [SAT_IN_W-1:0] SAT_MIN = -64'sh8000;
    function automatic logic [Q_DATA_W-1:0] sat_shift(input logic signed [SAT_IN_W-1:0] a);
        logic signed [SAT_IN_W-1:0] s;
        s = a >>> Q_FRAC_BITS;
        return s > SAT_MAX ? SAT_MAX[Q_DATA_W-1:0] : s < SAT_MIN ? SAT_MIN[Q_DATA_W-1:0] : s[Q_DATA_W-1:0];
    endfunction
endpackage

// File: rtl/neuron_mac_seq_if.sv
// neuron_mac_seq_if: input sample stream and result stream of the neuron MAC
interface neuron_mac_seq_if #(parameter int DATA_W = 16);
    logic in_valid;
    logic in_ready;
    logic [DATA_W-1:0] in_data;
    logic out_valid;
    logic out_ready;
    logic [DATA_W-1:0] out_data;
    logic out_fire;
    modport master (output in_valid, in_data, out_ready, input in_ready, out_valid, out_data, out_fire);
    modport slave (input in_valid, in_data, out_ready, output in_ready, out_valid, out_data, out_fire);
endinterface

// File: rtl/neuron_mac_dp.sv
// neuron_mac_dp: sample register, signed multiply, accumulator and saturated output register
module neuron_mac_dp
    import neuron_pkg::*;
#(
    parameter int DATA_W = Q_DATA_W,
    parameter int ACC_W = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic load,
    input  logic cap,
    input  logic [DATA_W-1:0] x_in,
    input  logic [DATA_W-1:0] w,
    output logic [DATA_W-1:0] out_data,
    output logic out_fire
);
    logic signed [DATA_W-1:0] x_q;
    logic pend;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] acc_nxt;
    logic signed [2*DATA_W-1:0] prod;
    logic [DATA_W-1:0] sat;
    always_comb begin
        prod = (2*DATA_W)'(x_q) * (2*DATA_W)'($signed(w));
        acc_nxt = pend ? acc + ACC_W'(prod) : acc;
        // the result is taken from acc_nxt so the final product lands on DONE entry
        sat = sat_shift(SAT_IN_W'(acc_nxt));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            pend <= 1'b0;
            acc <= '0;
            out_data <= '0;
            out_fire <= 1'b0;
        end else begin
            if (load) x_q <= x_in;
            pend <= load;
            acc <= clr ? '0 : acc_nxt;
            if (cap) begin
                out_data <= sat;
                out_fire <= !sat[DATA_W-1] && |sat;
            end
        end
    end
endmodule

// File: rtl/neuron_mac_seq.sv
// neuron_mac_seq: sequences weight ROM addresses, accepts one sample per weight and
// emits the saturated Q8.8 neuron sum with a step-activation fire bit
module neuron_mac_seq
    import neuron_pkg::*;
#(
    parameter int N_INPUTS = 10,
    parameter int ADDR_BASE = 1,
    parameter int DATA_W = Q_DATA_W,
    parameter int FRAC_BITS = Q_FRAC_BITS,
    parameter int ACC_W = 40
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    neuron_mac_seq_if.slave s,
    output logic [15:0] rom_addr,
    input  logic [DATA_W-1:0] rom_dout,
    output logic busy
);
    localparam int IDX_W = $clog2(N_INPUTS + 1);
    if (ACC_W < 2*DATA_W + $clog2(N_INPUTS) || ACC_W > SAT_IN_W || DATA_W != Q_DATA_W || FRAC_BITS != Q_FRAC_BITS) begin : g_bad_cfg
        $error("neuron_mac_seq: accumulator too narrow or format mismatch");
    end
    state_t state, state_nxt;
    logic [IDX_W-1:0] idx;
    logic accept;
    logic last;
    always_comb begin
        s.in_ready = state == RUN;
        s.out_valid = state == DONE;
        busy = state != IDLE;
        accept = s.in_valid && s.in_ready;
        last = accept && idx == IDX_W'(N_INPUTS - 1);
        rom_addr = state == RUN ? 16'(ADDR_BASE) + 16'(idx) : '0;
        state_nxt = state == IDLE  ? (start ? RUN : IDLE) :
                    state == RUN   ? (last ? DRAIN : RUN) :
                    state == DRAIN ? DONE :
                                     (s.out_ready ? IDLE : DONE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) idx <= '0;
            else if (accept) idx <= idx + IDX_W'(1);
        end
    end
    neuron_mac_dp #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_dp (
        .clk(clk),
        .rst_n(rst_n),
        .clr(state == IDLE && start),
        .load(accept),
        .cap(state == DRAIN),
        .x_in(s.in_data),
        .w(rom_dout),
        .out_data(s.out_data),
        .out_fire(s.out_fire)
    );
endmodule
